// File: rtl/string_pkg.sv
// string_pkg: shared types and constants for the string buffer and, later,
// the display block that consumes the same key event set.
//   state_t    : buffer controller states
//   event_t    : decoded edit/commit event, one per cycle
//   PRI_*      : bit positions in an event request vector, lowest index wins
//   pick_event : priority selector over a request vector
package string_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_NUL = 8'h00;

  localparam int unsigned PRI_DOWN  = 0;
  localparam int unsigned PRI_BKSP  = 1;
  localparam int unsigned PRI_ASCII = 2;
  localparam int unsigned PRI_LEFT  = 3;
  localparam int unsigned PRI_RIGHT = 4;
  localparam int unsigned NUM_EV    = 5;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_DOWN,
    EV_BKSP,
    EV_ASCII,
    EV_LEFT,
    EV_RIGHT
  } event_t;

  function automatic event_t pick_event(input logic [NUM_EV-1:0] req);
    if (req[PRI_DOWN])  return EV_DOWN;
    if (req[PRI_BKSP])  return EV_BKSP;
    if (req[PRI_ASCII]) return EV_ASCII;
    if (req[PRI_LEFT])  return EV_LEFT;
    if (req[PRI_RIGHT]) return EV_RIGHT;
    return EV_NONE;
  endfunction

endpackage

// File: rtl/string_tx.sv
// string_tx: streams the committed buffer out over valid/ready.
//   clk, i_rst_n : clock, async active-low reset
//   i_start      : pulse, restart the read index at 0
//   i_active     : controller is in SEND
//   i_len        : number of characters to send
//   o_rd_addr    : buffer read address
//   i_rd_data    : buffer read data at o_rd_addr
//   o_tx_data/o_tx_valid/o_tx_last/i_tx_ready : output stream
//   o_done       : pulse, final character accepted
module string_tx
  import string_pkg::*;
#(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_active,
  input  logic [AW:0]   i_len,
  output logic [AW-1:0] o_rd_addr,
  input  logic [DW-1:0] i_rd_data,
  output logic [DW-1:0] o_tx_data,
  output logic          o_tx_valid,
  output logic          o_tx_last,
  input  logic          i_tx_ready,
  output logic          o_done
);

  logic [AW:0] r_tx_idx;
  logic        w_last;
  logic        w_fire;

  assign w_last = i_active && (r_tx_idx == i_len - 1'b1);
  assign w_fire = i_active && i_tx_ready;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_idx <= '0;
    end else if (i_start) begin
      r_tx_idx <= '0;
    end else if (w_fire) begin
      r_tx_idx <= w_last ? '0 : r_tx_idx + 1'b1;
    end
  end

  // tx_idx < len <= DEPTH while active, so the low AW bits address the buffer
  assign o_rd_addr  = r_tx_idx[AW-1:0];
  assign o_tx_valid = i_active;
  assign o_tx_last  = w_last;
  // Data is gated so stale memory is never visible outside SEND
  assign o_tx_data  = i_active ? i_rd_data : DW'(ASCII_NUL);
  assign o_done     = w_fire && w_last;

endmodule

// File: rtl/string_buffer.sv
// string_buffer: editable line buffer fed by key_in events; a commit streams
// the line out byte-by-byte.
//   clk, i_rst_n      : clock, async active-low reset
//   i_ascii/_en       : write character at cursor (overwrite)
//   i_right_en/_left_en : cursor moves
//   i_backspace_en    : delete character left of cursor
//   i_down_en         : commit and transmit
//   o_tx_*/i_tx_ready : output stream
//   o_busy, o_full, o_len, o_cur, o_last_ascii : status/debug
module string_buffer
  import string_pkg::*;
#(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic [DW-1:0] i_ascii,
  input  logic          i_ascii_en,
  input  logic          i_right_en,
  input  logic          i_left_en,
  input  logic          i_backspace_en,
  input  logic          i_down_en,
  output logic [DW-1:0] o_tx_data,
  output logic          o_tx_valid,
  output logic          o_tx_last,
  input  logic          i_tx_ready,
  output logic          o_busy,
  output logic          o_full,
  output logic [AW:0]   o_len,
  output logic [AW:0]   o_cur,
  output logic [DW-1:0] o_last_ascii
);

  localparam int unsigned DEPTH   = 2**AW;
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_t            r_state;
  state_t            w_state_next;
  logic [DW-1:0]     r_mem [DEPTH];
  logic [AW:0]       r_len;
  logic [AW:0]       r_cur;
  logic [NUM_EV-1:0] w_req;
  event_t            w_ev;
  logic              w_wr_ok;
  logic              w_tx_start;
  logic              w_tx_done;
  logic              w_sending;
  logic [AW-1:0]     w_rd_addr;
  logic [DW-1:0]     w_rd_data;
  logic [AW-1:0]     w_last_idx;

  // Events are only decoded in IDLE; elsewhere every pulse is dropped
  always_comb begin
    w_req            = '0;
    w_req[PRI_DOWN]  = i_down_en;
    w_req[PRI_BKSP]  = i_backspace_en;
    w_req[PRI_ASCII] = i_ascii_en;
    w_req[PRI_LEFT]  = i_left_en;
    w_req[PRI_RIGHT] = i_right_en;
    w_ev             = (r_state == ST_IDLE) ? pick_event(w_req) : EV_NONE;
  end

  assign w_wr_ok    = (w_ev == EV_ASCII) && (r_cur != LEN_MAX);
  assign w_tx_start = (w_ev == EV_DOWN) && (r_len != '0);
  assign w_sending  = (r_state == ST_SEND);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_tx_start)
          w_state_next = ST_SEND;
        else if ((w_ev == EV_BKSP) && (r_cur != '0))
          w_state_next = ST_SHIFT;
      end
      ST_SHIFT: w_state_next = ST_IDLE;
      ST_SEND:  if (w_tx_done) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len <= '0;
      r_cur <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          case (w_ev)
            EV_ASCII: begin
              if (w_wr_ok) begin
                r_cur <= r_cur + 1'b1;
                if (r_cur == r_len) r_len <= r_len + 1'b1;
              end
            end
            EV_LEFT:  if (r_cur != '0)   r_cur <= r_cur - 1'b1;
            EV_RIGHT: if (r_cur < r_len) r_cur <= r_cur + 1'b1;
            default: ;
          endcase
        end
        ST_SHIFT: begin
          r_len <= r_len - 1'b1;
          r_cur <= r_cur - 1'b1;
        end
        ST_SEND: begin
          if (w_tx_done) begin
            r_len <= '0;
            r_cur <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is not reset; every output path that reads it is masked by
  // len/cur/state, which are.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_cur[AW-1:0]] <= i_ascii;
    end else if (r_state == ST_SHIFT) begin
      // Close the gap at cur-1 by pulling down every entry up to len-1
      for (int unsigned k = 0; k < DEPTH - 1; k++) begin
        if ((k + 1 >= 32'(r_cur)) && (k + 2 <= 32'(r_len)))
          r_mem[AW'(k)] <= r_mem[AW'(k + 1)];
      end
    end
  end

  assign w_rd_data  = r_mem[w_rd_addr];
  assign w_last_idx = AW'(r_cur - 1'b1);

  string_tx #(
    .AW(AW),
    .DW(DW)
  ) u_tx (
    .clk       (clk),
    .i_rst_n   (i_rst_n),
    .i_start   (w_tx_start),
    .i_active  (w_sending),
    .i_len     (r_len),
    .o_rd_addr (w_rd_addr),
    .i_rd_data (w_rd_data),
    .o_tx_data (o_tx_data),
    .o_tx_valid(o_tx_valid),
    .o_tx_last (o_tx_last),
    .i_tx_ready(i_tx_ready),
    .o_done    (w_tx_done)
  );

  assign o_busy       = (r_state != ST_IDLE);
  assign o_full       = (r_len == LEN_MAX);
  assign o_len        = r_len;
  assign o_cur        = r_cur;
  assign o_last_ascii = (r_cur == '0) ? DW'(ASCII_NUL) : r_mem[w_last_idx];

endmodule
